popcount_frame_accumulator: RTL and testbench

//   Downstream consumer of the 5:3 counter stage. Each beat takes the counter's

---
 rtl/popcount_frame_accumulator.sv | 132 +++++++++++++
 tb/tb_popcount_frame_accumulator.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/popcount_frame_accumulator.sv
// -----------------------------------------------------------------------------
// popcount_frame_accumulator
//
// Takes the three outputs of a 5:3 counter stage (sum, carry, cout) each beat,
// turns them into a 0..5 bit-count and accumulates that count over a frame.
// A frame ends on an accepted beat with in_last set, or on the FRAME_LEN-th
// accepted beat, whichever comes first. The frame result is then held on a
// valid/ready output port until the downstream side takes it.
//
// Parameters
//   FRAME_LEN  beats per frame when in_last is not used (>= 1)
//   ACC_W      width of out_total; the total saturates at 2^ACC_W-1
//   CNT_W      derived width of out_beats, $clog2(FRAME_LEN+1)
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous reset, active-high
//   in_valid   in   upstream beat valid
//   in_ready   out  a beat is accepted this cycle if in_valid is also high
//   in_sum     in   counter sum output, weight 1
//   in_carry   in   counter carry output, weight 2
//   in_cout    in   counter cout output, weight 2
//   in_last    in   beat closes the frame early
//   out_valid  out  frame result valid
//   out_ready  in   downstream accepts the result
//   out_total  out  saturated sum of beat values in the frame
//   out_beats  out  beats accepted in the frame (1..FRAME_LEN)
//   out_ovf    out  saturation occurred somewhere in the frame
// -----------------------------------------------------------------------------
module popcount_frame_accumulator #(
  parameter int FRAME_LEN = 8,
  parameter int ACC_W     = 8,
  localparam int CNT_W    = $clog2(FRAME_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sum,
  input  logic             in_carry,
  input  logic             in_cout,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_total,
  output logic [CNT_W-1:0] out_beats,
  output logic             out_ovf
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  // Three guard bits let acc + 5 be formed without wrapping for any ACC_W.
  localparam int              SUM_W    = ACC_W + 3;
  localparam logic [ACC_W-1:0] ACC_MAX = '1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  state_t           state;
  state_t           state_next;

  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] beat_cnt;
  logic             ovf;

  logic [2:0]       beat_val;
  logic [SUM_W-1:0] sum_raw;
  logic             sat_hit;
  logic [ACC_W-1:0] acc_sat;
  logic             accept;
  logic             frame_end;

  // Beat value: sum has weight 1, carry and cout both weight 2.
  assign beat_val = {2'b00, in_sum} + {1'b0, in_carry, 1'b0} + {1'b0, in_cout, 1'b0};

  assign sum_raw  = SUM_W'(acc) + SUM_W'(beat_val);
  assign sat_hit  = sum_raw > SUM_W'(ACC_MAX);
  assign acc_sat  = sat_hit ? ACC_MAX : sum_raw[ACC_W-1:0];

  // in_ready is forced low while reset is asserted so nothing is accepted
  // on the reset edge itself.
  assign in_ready  = (state == ACCUM) && !rst;
  assign accept    = in_valid && in_ready;
  assign frame_end = accept && (in_last || (beat_cnt == LAST_IDX));

  // The result register is loaded on the same edge the state enters HOLD,
  // so decoding out_valid from the state gives the one-cycle latency.
  assign out_valid = (state == HOLD);

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      ACCUM:   if (frame_end) state_next = HOLD;
      HOLD:    if (out_ready) state_next = ACCUM;
      default: state_next = ACCUM;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= ACCUM;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      beat_cnt  <= '0;
      ovf       <= 1'b0;
      out_total <= '0;
      out_beats <= '0;
      out_ovf   <= 1'b0;
    end else if (frame_end) begin
      // Publish the frame including this beat, and start the next frame clean.
      out_total <= acc_sat;
      out_beats <= beat_cnt + CNT_W'(1);
      out_ovf   <= ovf | sat_hit;
      acc       <= '0;
      beat_cnt  <= '0;
      ovf       <= 1'b0;
    end else if (accept) begin
      acc      <= acc_sat;
      beat_cnt <= beat_cnt + CNT_W'(1);
      ovf      <= ovf | sat_hit;
    end
  end

endmodule

// File: tb/tb_popcount_frame_accumulator.sv
// -----------------------------------------------------------------------------
// tb_popcount_frame_accumulator
//
// Two instances share one input stream: ACC_W=8 (no saturation for 8 beats
// of 5) and ACC_W=5 (saturates at 31). Sent beats are kept in a queue; the
// expected result of each frame is the plain sum of the queue, clamped to the
// instance's maximum, with overflow flagged when the unclamped sum exceeds it.
// -----------------------------------------------------------------------------
module tb_popcount_frame_accumulator;

  localparam int FRAME_LEN = 8;
  localparam int CNT_W     = $clog2(FRAME_LEN + 1);
  localparam int MAX_A     = 255;
  localparam int MAX_B     = 31;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_sum = 1'b0;
  logic             in_carry = 1'b0;
  logic             in_cout = 1'b0;
  logic             in_last = 1'b0;
  logic             out_ready = 1'b0;

  logic             a_in_ready, a_out_valid, a_out_ovf;
  logic [7:0]       a_out_total;
  logic [CNT_W-1:0] a_out_beats;
  logic             b_in_ready, b_out_valid, b_out_ovf;
  logic [4:0]       b_out_total;
  logic [CNT_W-1:0] b_out_beats;

  int n_checks = 0;
  int n_fail   = 0;
  int hold_cycles = 0;
  int beat_q[$];

  always #5 clk = ~clk;

  popcount_frame_accumulator #(.FRAME_LEN(FRAME_LEN), .ACC_W(8)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_sum(in_sum), .in_carry(in_carry), .in_cout(in_cout), .in_last(in_last),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_total(a_out_total),
    .out_beats(a_out_beats), .out_ovf(a_out_ovf)
  );

  popcount_frame_accumulator #(.FRAME_LEN(FRAME_LEN), .ACC_W(5)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_sum(in_sum), .in_carry(in_carry), .in_cout(in_cout), .in_last(in_last),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_total(b_out_total),
    .out_beats(b_out_beats), .out_ovf(b_out_ovf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int raw_total();
    int s = 0;
    foreach (beat_q[i]) s += beat_q[i];
    return s;
  endfunction

  function automatic int clamp(input int s, input int max);
    return (s > max) ? max : s;
  endfunction

  task automatic wait_ready();
    int t = 0;
    while (!a_in_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    check("in_ready_a", 32'(a_in_ready), 1);
    check("in_ready_b", 32'(b_in_ready), 1);
  endtask

  // Called #1 after the edge that accepted the frame-ending beat.
  task automatic check_frame();
    int raw = raw_total();
    int ta = clamp(raw, MAX_A);
    int tb = clamp(raw, MAX_B);
    int nb = beat_q.size();
    check("a_out_valid", 32'(a_out_valid), 1);
    check("a_out_total", 32'(a_out_total), 32'(ta));
    check("a_out_beats", 32'(a_out_beats), 32'(nb));
    check("a_out_ovf",   32'(a_out_ovf),   32'(raw > MAX_A));
    check("b_out_valid", 32'(b_out_valid), 1);
    check("b_out_total", 32'(b_out_total), 32'(tb));
    check("b_out_beats", 32'(b_out_beats), 32'(nb));
    check("b_out_ovf",   32'(b_out_ovf),   32'(raw > MAX_B));
    check("hold_in_ready", 32'(a_in_ready), 0);
    // Stall the output while pushing garbage at the input; nothing may move.
    for (int k = 0; k < hold_cycles; k++) begin
      out_ready = 1'b0;
      in_valid  = 1'b1;
      {in_sum, in_carry, in_cout, in_last} = 4'($urandom);
      @(posedge clk); #1;
      check("stall_valid", 32'(a_out_valid), 1);
      check("stall_total_a", 32'(a_out_total), 32'(ta));
      check("stall_total_b", 32'(b_out_total), 32'(tb));
      check("stall_beats", 32'(a_out_beats), 32'(nb));
      check("stall_in_ready", 32'(a_in_ready), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("post_hs_valid", 32'(a_out_valid), 0);
    check("post_hs_ready", 32'(a_in_ready), 1);
    beat_q.delete();
  endtask

  task automatic send_beat(input logic s, input logic c, input logic co,
                           input logic last, input int gap);
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      {in_sum, in_carry, in_cout, in_last} = 4'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_sum   = s;
    in_carry = c;
    in_cout  = co;
    in_last  = last;
    wait_ready();
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    beat_q.push_back(int'(s) + 2 * int'(c) + 2 * int'(co));
    if (last || beat_q.size() == FRAME_LEN) begin
      check_frame();
    end else begin
      check("mid_valid_a", 32'(a_out_valid), 0);
      check("mid_valid_b", 32'(b_out_valid), 0);
    end
  endtask

  task automatic full_frame(input logic s, input logic c, input logic co);
    for (int i = 0; i < FRAME_LEN; i++) send_beat(s, c, co, 1'b0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(a_in_ready), 0);
    check("rst_out_valid", 32'(a_out_valid), 0);
    check("rst_total", 32'(a_out_total), 0);
    check("rst_beats", 32'(a_out_beats), 0);
    check("rst_ovf", 32'(b_out_ovf), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_ready", 32'(a_in_ready), 1);

    // Full frame of v=5: 40 on the wide instance, 31 + ovf on the narrow one
    hold_cycles = 0;
    full_frame(1'b1, 1'b1, 1'b1);

    // Early close on the third beat: 1 + 2 + 4 = 7
    send_beat(1'b1, 1'b0, 1'b0, 1'b0, 0);
    send_beat(1'b0, 1'b1, 1'b0, 1'b0, 0);
    send_beat(1'b0, 1'b1, 1'b1, 1'b1, 0);

    // Output back-pressure for 5 cycles, then a fresh frame from zero
    hold_cycles = 5;
    full_frame(1'b1, 1'b1, 1'b1);
    hold_cycles = 0;
    full_frame(1'b1, 1'b1, 1'b1);

    // Value-1 frame after a saturated one: overflow must be clear
    full_frame(1'b1, 1'b0, 1'b0);

    // Single-beat frame
    send_beat(1'b0, 1'b1, 1'b0, 1'b1, 0);

    // Partial frame aborted by reset
    for (int i = 0; i < 4; i++) send_beat(1'b1, 1'b1, 1'b0, 1'b0, 0);
    rst = 1'b1;
    #1;
    check("abort_in_ready", 32'(a_in_ready), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    beat_q.delete();
    check("abort_out_valid", 32'(a_out_valid), 0);
    check("abort_total", 32'(a_out_total), 0);
    check("abort_beats", 32'(a_out_beats), 0);
    @(posedge clk); #1;
    check("abort_no_result", 32'(a_out_valid), 0);
    full_frame(1'b1, 1'b1, 1'b1);

    // Randomised frames with input gaps; the first closes on its 5th beat
    for (int f = 0; f < 30; f++) begin
      hold_cycles = $urandom_range(0, 3);
      for (int b = 0; b < FRAME_LEN; b++) begin
        logic last;
        if (f == 0) last = (b == 4);
        else        last = ($urandom_range(0, 3) == 0);
        send_beat(1'($urandom), 1'($urandom), 1'($urandom), last, $urandom_range(0, 3));
        if (last) break;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
